alu_share_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operations from the execute stage (port 0) and the branch/compare unit (port 1) through valid/ready handshakes, grants the ALU round-robin, and registers the result and flags. It returns them to the winning requester through a per-port response handshake. It owns the only instance of the ALU in the datapath.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_share_arbiter_alu.sv | 34 +++
 rtl/alu_share_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, width and arbiter state type
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_OR  = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_CMP = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - combinational 32-bit ALU with sign/zero flags
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              pos
);

  always_comb begin
    result = '0;
    case (op)
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      // unsigned three-way compare encoded as -1 / 0 / +1
      ALU_CMP: begin
        if (a == b)     result = '0;
        else if (a < b) result = '1;
        else            result = DATA_W'(1);
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[DATA_W-1];
  assign pos  = !zero && !neg;

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin two-port arbiter and sequencer for the shared ALU
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [2:0]        req_op0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [2:0]        req_op1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_neg,
  output logic              resp_pos,
  output logic              busy
);

  arb_state_t        state;
  logic              last_grant;
  logic              owner;
  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_neg;
  logic              alu_pos;

  // A tie goes to the port that was not served last; otherwise the sole requester wins.
  always_comb begin
    grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    req_ready = 2'b00;
    if (state == IDLE && req_valid[grant]) req_ready[grant] = 1'b1;
  end

  assign accept = |req_ready;
  assign busy   = (state != IDLE);

  alu_share_arbiter_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .zero   (alu_zero),
    .neg    (alu_neg),
    .pos    (alu_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_zero   <= 1'b1;
      resp_neg    <= 1'b0;
      resp_pos    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= grant ? req_a1  : req_a0;
            b_q        <= grant ? req_b1  : req_b0;
            op_q       <= grant ? req_op1 : req_op0;
            owner      <= grant;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp_neg    <= alu_neg;
          resp_pos    <= alu_pos;
          resp_valid  <= owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= 2'b00;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
